ssb_arbiter: RTL and testbench
==============================

// Module: ssb_arbiter
// PURPOSE
//  Arbitrates the shared system bus (SSB) between N hosts: Ibex instr, Ibex data, debug SBA.
//  Host 0 has the highest priority. Forwards one request per cycle to a single device port.
//  Tracks in-flight requests in an ID FIFO so each in-order device response returns to its issuing host.
//  Sits between ibex_top/dm_top host ports and the SSB device decode in ibex_super_system.
// PARAMETERS
//  NumHosts        3   number of bus hosts; index 0 = highest priority
//  AddrWidth       32  address width
//  DataWidth       32  data width; byte enables are DataWidth/8
//  MaxOutstanding  2   ID FIFO depth = max granted-but-unanswered requests (>=1)
//  StarveLimit     8   cycles a requesting host may be denied before forced grant (fixed-priority mode)
// PORTS
//  clk_sys_i          in   1                     system clock
//  rst_sys_ni         in   1                     async active-low reset
//  host_req_i         in   NumHosts              per-host request
//  host_we_i          in   NumHosts              per-host write enable
//  host_be_i          in   NumHosts*DataWidth/8  per-host byte enables
//  host_addr_i        in   NumHosts*AddrWidth    per-host address
//  host_wdata_i       in   NumHosts*DataWidth    per-host write data
//  host_gnt_o         out  NumHosts              per-host grant, one-hot or zero
//  host_rvalid_o      out  NumHosts              per-host response valid, one-hot or zero
//  host_rdata_o       out  DataWidth             response data, shared by all hosts
//  host_err_o         out  1                     response error, qualified by host_rvalid_o
//  dev_req_o          out  1                     device request
//  dev_we_o           out  1                     device write enable
//  dev_be_o           out  DataWidth/8           device byte enables
//  dev_addr_o         out  AddrWidth             device address
//  dev_wdata_o        out  DataWidth             device write data
//  dev_gnt_i          in   1                     device accepts dev_req_o this cycle
//  dev_rvalid_i       in   1                     device response, in order
//  dev_rdata_i        in   DataWidth             device read data
//  dev_err_i          in   1                     device error
//  unexp_rsp_o        out  1                     sticky flag: dev_rvalid_i seen while FIFO empty
// BEHAVIOUR
//  - Hosts follow the Ibex protocol: req and payload held stable until gnt. Transfer = req & gnt.
//  - Arbitration is combinational each cycle, with no lock between cycles.
//    - winner = lowest-index requester, unless a starvation override is active.
//    - can_issue = !fifo_full. A pop in the same cycle does NOT free a slot (no full bypass).
//    - dev_req_o = |host_req_i & can_issue. dev_* payload = winner's payload.
//    - dev_* payload = 0 when dev_req_o = 0.
//    - host_gnt_o[winner] = dev_req_o & dev_gnt_i. All other grants = 0.
//  - ID FIFO holds one entry per granted transfer, storing the winner's index.
//    - push on dev_req_o & dev_gnt_i. pop on dev_rvalid_i & !fifo_empty.
//    - simultaneous push and pop allowed whenever not full; occupancy unchanged.
//    - pointers wrap modulo MaxOutstanding.
//  - Response routing is combinational, latency 0 from dev_rvalid_i.
//    - host_rvalid_o[fifo_head] = dev_rvalid_i & !fifo_empty.
//    - host_rdata_o = dev_rdata_i; host_err_o = dev_err_i & dev_rvalid_i.
//    - dev_rvalid_i while FIFO empty: response dropped, unexp_rsp_o set (cleared only by reset).
//  - Starvation counter per host, width $clog2(StarveLimit+1), saturating.
//    - increments while host_req_i[i] & !host_gnt_o[i]; clears on grant or when req drops.
//    - counter == StarveLimit forces that host as winner; lowest index wins among starved hosts.
//  - Reset: FIFO empty; counters and unexp_rsp_o = 0.
//    - all host_gnt_o/host_rvalid_o/dev_req_o = 0 while rst_sys_ni low.
//  - Reset mid-transfer: in-flight IDs discarded. Later device responses raise unexp_rsp_o.
// CONFIGURATION
//  SSB_ARB_ROUND_ROBIN_EN defined:
//    - winner = first requester at or after rr_ptr, searching upward with wrap.
//    - rr_ptr <= winner+1 (mod NumHosts) on each transfer; rr_ptr resets to 0.
//    - starvation counters and the StarveLimit override are not built.
//  SSB_ARB_ROUND_ROBIN_EN undefined: fixed priority with starvation override as above.
// TESTING
//  1 Hosts 0,1,2 request together, dev_gnt_i=1, fixed mode -> grants h0,h0,.. h0 only; FIFO IDs 0.
//  2 Fixed mode: h0 requests continuously, h2 requests -> h2 granted in 9th cycle (after 8 denials).
//  3 MaxOutstanding=2, two grants, no dev_rvalid_i -> 3rd req: dev_req_o=0 until one rvalid.
//  4 Grant h1 then h0; two dev_rvalid_i, rdata A5A5A5A5 then 5A5A5A5A -> rvalid[1]=A5.., rvalid[0]=5A..
//  5 dev_rvalid_i with FIFO empty -> all host_rvalid_o=0, unexp_rsp_o=1 until reset.
//  6 ROUND_ROBIN_EN, all 3 requesting continuously -> grant order 0,1,2,0,1,2; reset mid-flight -> gnt=0, FIFO empty.

Source files
------------

// File: rtl/ssb_arbiter.sv
// SSB arbiter: forwards one host request per cycle to the device port and routes in-order
// responses back through an ID FIFO. Define SSB_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module ssb_arbiter #(
    parameter int unsigned NumHosts       = 3,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned StarveLimit    = 8
) (
    input  logic                              clk_sys_i,
    input  logic                              rst_sys_ni,
    input  logic [NumHosts-1:0]               host_req_i,
    input  logic [NumHosts-1:0]               host_we_i,
    input  logic [NumHosts*DataWidth/8-1:0]   host_be_i,
    input  logic [NumHosts*AddrWidth-1:0]     host_addr_i,
    input  logic [NumHosts*DataWidth-1:0]     host_wdata_i,
    output logic [NumHosts-1:0]               host_gnt_o,
    output logic [NumHosts-1:0]               host_rvalid_o,
    output logic [DataWidth-1:0]              host_rdata_o,
    output logic                              host_err_o,
    output logic                              dev_req_o,
    output logic                              dev_we_o,
    output logic [DataWidth/8-1:0]            dev_be_o,
    output logic [AddrWidth-1:0]              dev_addr_o,
    output logic [DataWidth-1:0]              dev_wdata_o,
    input  logic                              dev_gnt_i,
    input  logic                              dev_rvalid_i,
    input  logic [DataWidth-1:0]              dev_rdata_i,
    input  logic                              dev_err_i,
    output logic                              unexp_rsp_o
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned IdxW    = (NumHosts > 1) ? $clog2(NumHosts) : 1;
    localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);

    logic [IdxW-1:0]     r_fifo_id [MaxOutstanding];
    logic [PtrW-1:0]     r_wr_ptr;
    logic [PtrW-1:0]     r_rd_ptr;
    logic [CntW-1:0]     r_count;
    logic                r_unexp;

    logic                w_full;
    logic                w_empty;
    logic                w_dev_req;
    logic                w_push;
    logic                w_pop;
    logic [IdxW-1:0]     w_winner;
    logic [IdxW-1:0]     w_head;
    logic [NumHosts-1:0] w_gnt;
    logic [NumHosts-1:0] w_rvalid;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // No full bypass: a same-cycle pop does not open a slot for a new issue.
    assign w_full    = (r_count == CntW'(MaxOutstanding));
    assign w_empty   = (r_count == '0);
    assign w_dev_req = rst_sys_ni & (|host_req_i) & ~w_full;
    assign w_push    = w_dev_req & dev_gnt_i;
    assign w_pop     = rst_sys_ni & dev_rvalid_i & ~w_empty;
    assign w_head    = r_fifo_id[r_rd_ptr];

`ifdef SSB_ARB_ROUND_ROBIN_EN
    logic [IdxW-1:0]     r_rr_ptr;
    logic [NumHosts-1:0] w_req_hi;

    // Requesters at or above the pointer take precedence; otherwise wrap to the lowest index.
    always_comb begin
        w_req_hi = '0;
        w_winner = '0;
        for (int unsigned i = 0; i < NumHosts; i++) begin
            w_req_hi[i] = host_req_i[i] & (IdxW'(i) >= r_rr_ptr);
        end
        for (int unsigned i = NumHosts; i > 0; i--) begin
            if ((|w_req_hi) ? w_req_hi[i-1] : host_req_i[i-1]) begin
                w_winner = IdxW'(i - 1);
            end
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_rr_ptr <= '0;
        end else if (w_push) begin
            r_rr_ptr <= (w_winner == IdxW'(NumHosts - 1)) ? '0 : w_winner + 1'b1;
        end
    end
`else
    localparam int unsigned StW = $clog2(StarveLimit + 1);

    logic [StW-1:0] r_starve [NumHosts];

    // Plain lowest-index pass first; a starved requester then overrides it.
    always_comb begin
        w_winner = '0;
        for (int unsigned i = NumHosts; i > 0; i--) begin
            if (host_req_i[i-1]) begin
                w_winner = IdxW'(i - 1);
            end
        end
        for (int unsigned i = NumHosts; i > 0; i--) begin
            if (host_req_i[i-1] && (r_starve[i-1] == StW'(StarveLimit))) begin
                w_winner = IdxW'(i - 1);
            end
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            for (int unsigned i = 0; i < NumHosts; i++) begin
                r_starve[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumHosts; i++) begin
                if (host_req_i[i] && !w_gnt[i]) begin
                    if (r_starve[i] != StW'(StarveLimit)) begin
                        r_starve[i] <= r_starve[i] + 1'b1;
                    end
                end else begin
                    r_starve[i] <= '0;
                end
            end
        end
    end
`endif

    always_comb begin
        w_gnt = '0;
        if (w_push) begin
            w_gnt[w_winner] = 1'b1;
        end
        w_rvalid = '0;
        if (w_pop) begin
            w_rvalid[w_head] = 1'b1;
        end
    end

    always_comb begin
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        dev_addr_o  = '0;
        dev_wdata_o = '0;
        if (w_dev_req) begin
            for (int unsigned i = 0; i < NumHosts; i++) begin
                if (w_winner == IdxW'(i)) begin
                    dev_we_o    = host_we_i[i];
                    dev_be_o    = host_be_i[i*BeWidth +: BeWidth];
                    dev_addr_o  = host_addr_i[i*AddrWidth +: AddrWidth];
                    dev_wdata_o = host_wdata_i[i*DataWidth +: DataWidth];
                end
            end
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                r_fifo_id[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_unexp  <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo_id[r_wr_ptr] <= w_winner;
                r_wr_ptr            <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (dev_rvalid_i && w_empty) begin
                r_unexp <= 1'b1;
            end
        end
    end

    assign dev_req_o     = w_dev_req;
    assign host_gnt_o    = w_gnt;
    assign host_rvalid_o = w_rvalid;
    assign host_rdata_o  = dev_rdata_i;
    assign host_err_o    = dev_err_i & dev_rvalid_i;
    assign unexp_rsp_o   = r_unexp;

endmodule

// File: tb/tb_ssb_arbiter.sv
// Randomized and directed bench for ssb_arbiter against a queue-based reference model.
// Follows SSB_ARB_ROUND_ROBIN_EN in the same way as the design.
module tb_ssb_arbiter;

    localparam int NH = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 2;
    localparam int SL = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NH-1:0]    h_req;
    logic [NH-1:0]    h_we;
    logic [NH*BW-1:0] h_be;
    logic [NH*AW-1:0] h_addr;
    logic [NH*DW-1:0] h_wdata;
    logic             d_gnt;
    logic             d_rv;
    logic [DW-1:0]    d_rdata;
    logic             d_err;

    logic [NH-1:0]    host_gnt_o;
    logic [NH-1:0]    host_rvalid_o;
    logic [DW-1:0]    host_rdata_o;
    logic             host_err_o;
    logic             dev_req_o;
    logic             dev_we_o;
    logic [BW-1:0]    dev_be_o;
    logic [AW-1:0]    dev_addr_o;
    logic [DW-1:0]    dev_wdata_o;
    logic             unexp_rsp_o;

    ssb_arbiter #(
        .NumHosts       (NH),
        .AddrWidth      (AW),
        .DataWidth      (DW),
        .MaxOutstanding (MO),
        .StarveLimit    (SL)
    ) dut (
        .clk_sys_i     (clk),
        .rst_sys_ni    (rst_n),
        .host_req_i    (h_req),
        .host_we_i     (h_we),
        .host_be_i     (h_be),
        .host_addr_i   (h_addr),
        .host_wdata_i  (h_wdata),
        .host_gnt_o    (host_gnt_o),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .host_err_o    (host_err_o),
        .dev_req_o     (dev_req_o),
        .dev_we_o      (dev_we_o),
        .dev_be_o      (dev_be_o),
        .dev_addr_o    (dev_addr_o),
        .dev_wdata_o   (dev_wdata_o),
        .dev_gnt_i     (d_gnt),
        .dev_rvalid_i  (d_rv),
        .dev_rdata_i   (d_rdata),
        .dev_err_i     (d_err),
        .unexp_rsp_o   (unexp_rsp_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: outstanding host IDs, denial counts, sticky flag, rotation pointer.
    int  q[$];
    int  cnt[NH];
    bit  m_unexp;
    int  rr;
    bit  pend[NH];
    int  p_req, p_gnt, p_rv;

    logic [NH-1:0] e_gnt;
    logic [NH-1:0] e_rv;
    bit            e_dreq;
    int            e_win;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        foreach (cnt[i]) cnt[i] = 0;
        m_unexp = 1'b0;
        rr = 0;
    endfunction

    function automatic void model_eval();
        int w;
        w = -1;
`ifdef SSB_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < NH; k++) begin
            int j;
            j = (rr + k) % NH;
            if (w < 0 && h_req[j]) w = j;
        end
`else
        for (int i = 0; i < NH; i++) if (w < 0 && h_req[i] && cnt[i] == SL) w = i;
        for (int i = 0; i < NH; i++) if (w < 0 && h_req[i]) w = i;
`endif
        e_win  = w;
        e_dreq = rst_n && (w >= 0) && (q.size() < MO);
        e_gnt  = '0;
        if (e_dreq && d_gnt) e_gnt[w] = 1'b1;
        e_rv   = '0;
        if (rst_n && d_rv && q.size() > 0) e_rv[q[0]] = 1'b1;
    endfunction

    task automatic eval_check();
        logic          ewe;
        logic [BW-1:0] ebe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        #1;
        model_eval();
        ewe = 1'b0; ebe = '0; ea = '0; ewd = '0;
        if (e_dreq) begin
            ewe = h_we[e_win];
            ebe = h_be[e_win*BW +: BW];
            ea  = h_addr[e_win*AW +: AW];
            ewd = h_wdata[e_win*DW +: DW];
        end
        chk("dev_req", dev_req_o, e_dreq);
        chk("gnt", host_gnt_o, e_gnt);
        chk("rvalid", host_rvalid_o, e_rv);
        chk("rdata", host_rdata_o, d_rdata);
        chk("err", host_err_o, d_err & d_rv);
        chk("dev_we", dev_we_o, ewe);
        chk("dev_be", dev_be_o, ebe);
        chk("dev_addr", dev_addr_o, ea);
        chk("dev_wdata", dev_wdata_o, ewd);
        chk("unexp", unexp_rsp_o, m_unexp);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) begin
            if (d_rv) begin
                if (q.size() > 0) void'(q.pop_front());
                else m_unexp = 1'b1;
            end
            if (e_gnt != '0) begin
                q.push_back(e_win);
                rr = (e_win + 1) % NH;
                pend[e_win] = 1'b0;
            end
            for (int i = 0; i < NH; i++) begin
                if (h_req[i] && !e_gnt[i]) cnt[i] = (cnt[i] < SL) ? cnt[i] + 1 : SL;
                else cnt[i] = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        h_req = '0;
        d_gnt = 1'b0;
        for (int c = 0; c < MO + 2; c++) begin
            d_rv = (q.size() > 0);
            d_rdata = $urandom;
            eval_check();
            advance();
        end
        d_rv = 1'b0;
    endtask

    task automatic drive_random();
        if (!rst_n) rst_n = 1'b1;
        else if ($urandom_range(299) == 0) begin
            rst_n = 1'b0;
            model_reset();
        end
        for (int i = 0; i < NH; i++) begin
            if (!pend[i] && $urandom_range(99) < p_req) begin
                pend[i] = 1'b1;
                h_we[i] = 1'($urandom);
                h_be[i*BW +: BW] = BW'($urandom);
                h_addr[i*AW +: AW] = $urandom;
                h_wdata[i*DW +: DW] = $urandom;
            end
            h_req[i] = pend[i];
        end
        d_gnt = ($urandom_range(99) < p_gnt);
        d_rv = (q.size() > 0) ? ($urandom_range(99) < p_rv) : ($urandom_range(99) == 0);
        d_rdata = $urandom;
        d_err = 1'($urandom);
    endtask

    initial begin
        int first;
        model_reset();
        foreach (pend[i]) pend[i] = 1'b0;
        h_we = '1; h_be = '1; d_err = 1'b0; d_rdata = '0;
        for (int i = 0; i < NH; i++) begin
            h_addr[i*AW +: AW] = 32'h1000_0000 + i * 32'h100;
            h_wdata[i*DW +: DW] = $urandom;
        end

        // Reset holds all grants/valids low even with requests and responses present
        h_req = '1; d_gnt = 1'b1; d_rv = 1'b1;
        @(negedge clk);
        eval_check();
        chk("rst_gnt", host_gnt_o, 0);
        chk("rst_dev_req", dev_req_o, 0);
        chk("rst_rvalid", host_rvalid_o, 0);
        advance();
        rst_n = 1'b1; h_req = '0; d_rv = 1'b0;

`ifndef SSB_ARB_ROUND_ROBIN_EN
        h_req = '1; d_gnt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            d_rv = (q.size() > 0);
            eval_check();
            chk("t1_gnt_h0", host_gnt_o, 3'b001);
            chk("t1_rv_id0", host_rvalid_o, d_rv ? 3'b001 : 3'b000);
            advance();
        end
        drain();

        h_req = 3'b101; d_gnt = 1'b1; first = 0;
        for (int c = 1; c <= 12; c++) begin
            d_rv = (q.size() > 0);
            eval_check();
            if (host_gnt_o[2] && first == 0) first = c;
            advance();
            if (first != 0) h_req[2] = 1'b0;
        end
        chk("t2_starve_cycle", first, 9);
        drain();
`endif

        h_req = 3'b001; d_gnt = 1'b1; d_rv = 1'b0;
        for (int c = 0; c < 2; c++) begin
            eval_check();
            chk("t3_issue", dev_req_o, 1);
            advance();
        end
        eval_check();
        chk("t3_full", dev_req_o, 0);
        advance();
        d_rv = 1'b1;
        eval_check();
        chk("t3_no_bypass", dev_req_o, 0);
        chk("t3_rv_h0", host_rvalid_o, 3'b001);
        advance();
        d_rv = 1'b0;
        eval_check();
        chk("t3_reissue", dev_req_o, 1);
        advance();
        drain();

        d_gnt = 1'b1;
        h_req = 3'b010;
        eval_check();
        chk("t4_gnt_h1", host_gnt_o, 3'b010);
        advance();
        h_req = 3'b001;
        eval_check();
        chk("t4_gnt_h0", host_gnt_o, 3'b001);
        advance();
        h_req = '0; d_rv = 1'b1; d_rdata = 32'hA5A5_A5A5;
        eval_check();
        chk("t4_rv_h1", host_rvalid_o, 3'b010);
        chk("t4_rdata_a5", host_rdata_o, 32'hA5A5_A5A5);
        advance();
        d_rdata = 32'h5A5A_5A5A;
        eval_check();
        chk("t4_rv_h0", host_rvalid_o, 3'b001);
        chk("t4_rdata_5a", host_rdata_o, 32'h5A5A_5A5A);
        advance();

        d_rv = 1'b1;
        eval_check();
        chk("t5_rv_none", host_rvalid_o, 0);
        advance();
        d_rv = 1'b0;
        for (int c = 0; c < 3; c++) begin
            eval_check();
            chk("t5_unexp_sticky", unexp_rsp_o, 1);
            advance();
        end
        rst_n = 1'b0;
        model_reset();
        eval_check();
        chk("t5_unexp_clr", unexp_rsp_o, 0);
        advance();
        rst_n = 1'b1;

`ifdef SSB_ARB_ROUND_ROBIN_EN
        h_req = '1; d_gnt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            d_rv = (q.size() > 0);
            eval_check();
            chk("t6_rr_order", host_gnt_o, NH'(1) << (c % NH));
            advance();
        end
        drain();
`endif

        // Reset with two IDs in flight: later responses must be treated as unexpected
        h_req = 3'b001; d_gnt = 1'b1; d_rv = 1'b0;
        for (int c = 0; c < 2; c++) begin
            eval_check();
            advance();
        end
        rst_n = 1'b0;
        model_reset();
        eval_check();
        chk("rstmid_gnt", host_gnt_o, 0);
        advance();
        rst_n = 1'b1; h_req = '0; d_rv = 1'b1;
        eval_check();
        chk("rstmid_drop", host_rvalid_o, 0);
        advance();
        d_rv = 1'b0;
        eval_check();
        chk("rstmid_unexp", unexp_rsp_o, 1);
        advance();
        rst_n = 1'b0;
        model_reset();
        eval_check();
        advance();
        rst_n = 1'b1;

        for (int blk = 0; blk < 8; blk++) begin
            p_req = (blk % 2 == 0) ? 90 : 40;
            p_gnt = (blk % 4 < 2) ? 85 : 40;
            p_rv  = (blk % 3 == 0) ? 20 : 70;
            for (int c = 0; c < 500; c++) begin
                drive_random();
                eval_check();
                advance();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
